// File: rtl/text_pkg.sv
//------------------------------------------------------------------------------
// Module      : text_pkg
// Description : Shared geometry, control codes and state type for the text
//               page writer.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 13;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/text_write_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : text_write_ctrl_if
// Description : Byte-stream handshake and memory write bus of the text writer.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface text_write_ctrl_if import text_pkg::*; #(
    parameter int AW = ADDR_W
) ();

    logic [7:0]    in_char;
    logic [7:0]    in_colour;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_char;
    logic [7:0]    wr_colour;
    logic          wr_char_en;
    logic          wr_colour_en;
    logic [AW-1:0] cursor_pos;
    logic          busy;

    // Upstream feeder / memory side
    modport master (
        output in_char, in_colour, in_valid,
        input  in_ready, wr_addr, wr_char, wr_colour,
        input  wr_char_en, wr_colour_en, cursor_pos, busy
    );

    // The write controller itself
    modport slave (
        input  in_char, in_colour, in_valid,
        output in_ready, wr_addr, wr_char, wr_colour,
        output wr_char_en, wr_colour_en, cursor_pos, busy
    );

endinterface

`default_nettype wire

// File: rtl/text_write_ctrl_cell_counter.sv
//------------------------------------------------------------------------------
// Module      : cell_counter
// Description : Modulo-DEPTH up/down counter with synchronous load.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cell_counter import text_pkg::*; #(
    parameter int DEPTH = CELLS,
    parameter int WIDTH = ADDR_W
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_inc,
    input  wire logic             i_dec,
    output logic      [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] r_count;

    // Load wins over counting; increment wins over decrement
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= (r_count == c_last) ? '0 : r_count + WIDTH'(1);
        end else if (i_dec) begin
            r_count <= (r_count == '0) ? c_last : r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/text_write_ctrl.sv
//------------------------------------------------------------------------------
// Module      : text_write_ctrl
// Description : Byte-stream writer for the character/colour text-page memories,
//               handling CR/LF/BS/FF and writing only while DISP is low.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module text_write_ctrl #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 60,
    parameter int         ADDR_W       = 13,
    parameter logic [7:0] CLEAR_CHAR   = 8'h20,
    parameter logic [7:0] CLEAR_COLOUR = 8'h07
) (
    input  wire logic          CLOCK_50,
    input  wire logic          RESET_N,
    input  wire logic          DISP,
    text_write_ctrl_if.slave   bus
);

    import text_pkg::state_t;
    import text_pkg::IDLE;
    import text_pkg::WRITE;
    import text_pkg::CLEAR;
    import text_pkg::CC_BS;
    import text_pkg::CC_LF;
    import text_pkg::CC_FF;
    import text_pkg::CC_CR;

    localparam int                CELLS       = COLS * ROWS;
    localparam logic [ADDR_W-1:0] c_last_cell = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] c_cols      = ADDR_W'(COLS);
    localparam logic [ADDR_W:0]   c_cols_ext  = (ADDR_W+1)'(COLS);
    localparam logic [ADDR_W:0]   c_cells_ext = (ADDR_W+1)'(CELLS);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_char;
    logic [7:0]        r_colour;
    logic              r_ctrl_pending;
    logic              r_dec_pending;

    logic              w_accept;
    logic              w_in_is_move;
    logic [ADDR_W-1:0] w_cursor;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_cr_target;
    logic [ADDR_W:0]   w_lf_sum;
    logic [ADDR_W-1:0] w_lf_target;

    logic              w_cur_load;
    logic [ADDR_W-1:0] w_cur_load_val;
    logic              w_cur_inc;
    logic              w_cur_dec;
    logic              w_clr_load;
    logic              w_clr_inc;
    logic              w_wr_req;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [7:0]        w_wr_char;
    logic [7:0]        w_wr_colour;

    assign w_accept     = bus.in_valid && (r_state == IDLE);
    assign w_in_is_move = (bus.in_char == CC_CR) || (bus.in_char == CC_LF);

    assign w_col       = w_cursor % c_cols;
    assign w_cr_target = w_cursor - w_col;
    assign w_lf_sum    = {1'b0, w_cursor} + c_cols_ext;
    assign w_lf_target = (w_lf_sum >= c_cells_ext) ? ADDR_W'(w_lf_sum - c_cells_ext)
                                                   : w_lf_sum[ADDR_W-1:0];

    cell_counter #(
        .DEPTH (CELLS),
        .WIDTH (ADDR_W)
    ) u_cursor (
        .i_clk      (CLOCK_50),
        .i_rst_n    (RESET_N),
        .i_load     (w_cur_load),
        .i_load_val (w_cur_load_val),
        .i_inc      (w_cur_inc),
        .i_dec      (w_cur_dec),
        .o_count    (w_cursor)
    );

    cell_counter #(
        .DEPTH (CELLS),
        .WIDTH (ADDR_W)
    ) u_clear_addr (
        .i_clk      (CLOCK_50),
        .i_rst_n    (RESET_N),
        .i_load     (w_clr_load),
        .i_load_val ('0),
        .i_inc      (w_clr_inc),
        .i_dec      (1'b0),
        .o_count    (w_clr_addr)
    );

    // CR/LF move the cursor one edge after acceptance; BS decrements in its
    // first WRITE cycle, before the blanking write.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= IDLE;
            r_char         <= '0;
            r_colour       <= '0;
            r_ctrl_pending <= 1'b0;
            r_dec_pending  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_ctrl_pending <= w_accept && w_in_is_move;
            r_dec_pending  <= w_accept && (bus.in_char == CC_BS);
            if (w_accept) begin
                r_char   <= bus.in_char;
                r_colour <= bus.in_colour;
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_cur_load     = 1'b0;
        w_cur_load_val = w_cursor;
        w_cur_inc      = 1'b0;
        w_cur_dec      = 1'b0;
        w_clr_load     = 1'b0;
        w_clr_inc      = 1'b0;
        w_wr_req       = 1'b0;
        w_wr_addr      = w_cursor;
        w_wr_char      = r_char;
        w_wr_colour    = r_colour;

        case (r_state)
            IDLE: begin
                if (r_ctrl_pending) begin
                    w_cur_load     = 1'b1;
                    w_cur_load_val = (r_char == CC_CR) ? w_cr_target : w_lf_target;
                end
                if (w_accept) begin
                    if (bus.in_char == CC_FF) begin
                        w_next_state = CLEAR;
                        w_clr_load   = 1'b1;
                    end else if (!w_in_is_move) begin
                        w_next_state = WRITE;
                    end
                end
            end

            WRITE: begin
                if (r_dec_pending) begin
                    w_cur_dec = 1'b1;
                end else begin
                    w_wr_req = 1'b1;
                    if (r_char == CC_BS) begin
                        w_wr_char   = CLEAR_CHAR;
                        w_wr_colour = CLEAR_COLOUR;
                    end
                    if (!DISP) begin
                        w_cur_inc    = (r_char != CC_BS);
                        w_next_state = IDLE;
                    end
                end
            end

            CLEAR: begin
                w_wr_req    = 1'b1;
                w_wr_addr   = w_clr_addr;
                w_wr_char   = CLEAR_CHAR;
                w_wr_colour = CLEAR_COLOUR;
                if (!DISP) begin
                    w_clr_inc = 1'b1;
                    if (w_clr_addr == c_last_cell) begin
                        w_cur_load     = 1'b1;
                        w_cur_load_val = '0;
                        w_next_state   = IDLE;
                    end
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.in_ready     = (r_state == IDLE);
    assign bus.busy         = (r_state != IDLE);
    assign bus.cursor_pos   = w_cursor;
    assign bus.wr_addr      = w_wr_addr;
    assign bus.wr_char      = w_wr_char;
    assign bus.wr_colour    = w_wr_colour;
    assign bus.wr_char_en   = w_wr_req & ~DISP;
    assign bus.wr_colour_en = w_wr_req & ~DISP;

endmodule

`default_nettype wire

// File: tb/tb_text_write_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_text_write_ctrl
// Description : Self-checking bench for text_write_ctrl against a cell-level
//               reference model of the text page.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_text_write_ctrl;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    logic DISP     = 1'b0;

    text_write_ctrl_if #(.AW(13)) bus ();

    text_write_ctrl #(
        .COLS         (80),
        .ROWS         (60),
        .ADDR_W       (13),
        .CLEAR_CHAR   (8'h20),
        .CLEAR_COLOUR (8'h07)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .DISP     (DISP),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int addr;
        int ch;
        int col;
    } wr_t;

    wr_t exp_q[$];
    int  m_cursor  = 0;
    int  n_checks  = 0;
    int  n_fails   = 0;
    int  disp_mode = 0;
    int  disp_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push_wr(input int a, input int c, input int k);
        wr_t e;
        e.addr = a;
        e.ch   = c;
        e.col  = k;
        exp_q.push_back(e);
    endfunction

    // Page-level effect of one accepted byte
    function automatic void model_apply(input logic [7:0] ch, input logic [7:0] col);
        case (ch)
            8'h0D: m_cursor = m_cursor - (m_cursor % 80);
            8'h0A: m_cursor = (m_cursor + 80) % 4800;
            8'h08: begin
                m_cursor = (m_cursor + 4799) % 4800;
                push_wr(m_cursor, 8'h20, 8'h07);
            end
            8'h0C: begin
                for (int a = 0; a < 4800; a++) push_wr(a, 8'h20, 8'h07);
                m_cursor = 0;
            end
            default: begin
                push_wr(m_cursor, ch, col);
                m_cursor = (m_cursor + 1) % 4800;
            end
        endcase
    endfunction

    always @(negedge CLOCK_50) begin
        disp_cnt++;
        case (disp_mode)
            0:       DISP = 1'b0;
            1:       DISP = ($urandom % 4 == 0);
            2:       DISP = ((disp_cnt % 160) < 100);
            default: DISP = 1'b1;
        endcase
    end

    // Every strobe must match the next expected cell write, in order
    always @(negedge CLOCK_50) begin
        #1;
        if (RESET_N && (bus.wr_char_en || bus.wr_colour_en)) begin
            wr_t e;
            chk("write_while_disp", DISP, 0);
            chk("strobe_pair", bus.wr_colour_en, bus.wr_char_en);
            if (exp_q.size() == 0) begin
                e.addr = -1; e.ch = -1; e.col = -1;
            end else begin
                e = exp_q.pop_front();
            end
            chk("wr_addr", bus.wr_addr, e.addr);
            chk("wr_char", bus.wr_char, e.ch);
            chk("wr_colour", bus.wr_colour, e.col);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLOCK_50);
        while (bus.busy && n < 20000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 20000) chk("busy_timeout", bus.busy, 0);
        @(negedge CLOCK_50);
        #2;
    endtask

    task automatic send(input logic [7:0] ch, input logic [7:0] col, input string tag);
        int n = 0;
        @(negedge CLOCK_50);
        bus.in_char   = ch;
        bus.in_colour = col;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < 20000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 20000) chk("ready_timeout", bus.in_ready, 1);
        @(posedge CLOCK_50);
        #1;
        bus.in_valid = 1'b0;
        model_apply(ch, col);
        wait_idle();
        chk({tag, "_cursor"}, bus.cursor_pos, m_cursor);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bus.in_char   = '0;
        bus.in_colour = '0;
        bus.in_valid  = 1'b0;

        repeat (3) @(negedge CLOCK_50);
        #2;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cursor", bus.cursor_pos, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_char", bus.wr_char, 0);
        chk("rst_wr_colour", bus.wr_colour, 0);
        chk("rst_strobe", bus.wr_char_en, 0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        // 'A' at cell 0: strobe one cycle after accept, ready low one cycle
        @(negedge CLOCK_50);
        bus.in_char = 8'h41; bus.in_colour = 8'h1F; bus.in_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        bus.in_valid = 1'b0;
        model_apply(8'h41, 8'h1F);
        chk("first_strobe_latency", bus.wr_char_en, 1);
        @(negedge CLOCK_50);
        #2;
        chk("ready_low_one_cycle", bus.in_ready, 0);
        @(negedge CLOCK_50);
        #2;
        chk("ready_back_high", bus.in_ready, 1);
        chk("cursor_after_A", bus.cursor_pos, 1);

        send(8'h0D, 8'h00, "cr_to_0");
        send(8'h08, 8'h00, "bs_wrap");
        send(8'h5A, 8'h33, "z_at_last");
        send(8'h0A, 8'h00, "lf_80");
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 8'h12, "fill");
        send(8'h0D, 8'h00, "cr_85");

        disp_mode = 2;
        send(8'h0C, 8'h00, "ff_toggled");
        chk("ff_busy_low", bus.busy, 0);
        disp_mode = 0;

        for (int i = 0; i < 5; i++) send(8'h08, 8'h00, "bs_back");
        send(8'h0A, 8'h00, "lf_wrap");

        // Held off by DISP, then released
        disp_mode = 3;
        repeat (2) @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.in_char = 8'h51; bus.in_colour = 8'h4E; bus.in_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        bus.in_valid = 1'b0;
        model_apply(8'h51, 8'h4E);
        repeat (5) @(negedge CLOCK_50);
        #2;
        chk("disp_hold_busy", bus.busy, 1);
        chk("disp_hold_no_strobe", bus.wr_char_en, 0);
        chk("disp_hold_queued", exp_q.size(), 1);
        disp_mode = 0;
        @(negedge CLOCK_50);
        #2;
        chk("disp_release_strobe", bus.wr_char_en, 1);
        wait_idle();
        chk("disp_release_cursor", bus.cursor_pos, m_cursor);

        disp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom % 8)
                0: b = 8'h0D;
                1: b = 8'h0A;
                2: b = 8'h08;
                default: begin
                    b = 8'($urandom);
                    while (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D)
                        b = 8'($urandom);
                end
            endcase
            send(b, 8'($urandom), "rand");
        end
        disp_mode = 0;

        // Async reset in the middle of a clear
        @(negedge CLOCK_50);
        bus.in_char = 8'h0C; bus.in_colour = 8'h00; bus.in_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        bus.in_valid = 1'b0;
        model_apply(8'h0C, 8'h00);
        repeat (1000) @(negedge CLOCK_50);
        #3;
        chk("mid_clear_busy", bus.busy, 1);
        RESET_N = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_cursor", bus.cursor_pos, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_strobe", bus.wr_char_en, 0);
        exp_q.delete();
        m_cursor = 0;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        send(8'h42, 8'h0E, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
